// File: rtl/lab1_sweep_checker.sv
// ---------------------------------------------------------------------------
// lab1_sweep_checker
//
// Purpose: drives every 6-bit input combination {i1,i0,b1,b0,a1,a0} to two
// implementations of the same 2-output circuit. For each vector it waits
// SETTLE cycles and then compares the two 2-bit results. It counts the
// mismatches and records the first vector that mismatched.
//
// Parameters:
//   SETTLE          cycles (1..15) between driving a vector and sampling it
//
// Ports:
//   clk             single clock, rising-edge
//   rst_n           asynchronous active-low reset
//   start           level; begins a 64-vector sweep when sampled in IDLE
//   abort           ends a sweep in progress (no done pulse, pass=0)
//   vec_out[5:0]    stimulus: [0]=a0 [1]=a1 [2]=b0 [3]=b1 [4]=i0 [5]=i1
//   res_a[1:0]      {f1,f0} from the functional implementation
//   res_b[1:0]      {f1,f0} from the executional / block-diagram version
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of a completed sweep
//   pass            last completed sweep had no mismatches
//   err_count[6:0]  mismatch count, 0..64
//   first_err_vec   vec_out value of the first mismatch
//   first_err_valid first_err_vec holds a captured value
// ---------------------------------------------------------------------------
module lab1_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [5:0] vec_out,
  input  logic [1:0] res_a,
  input  logic [1:0] res_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_count,
  output logic [5:0] first_err_vec,
  output logic       first_err_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last value of the wait counter before leaving SETTLE.
  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] vec_q, vec_d;
  logic [3:0] wait_q, wait_d;
  logic [6:0] err_q, err_d;
  logic [5:0] ferr_vec_q, ferr_vec_d;
  logic       ferr_valid_q, ferr_valid_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  assign mismatch = (res_a != res_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 6'd0;
      vec_q        <= 6'd0;
      wait_q       <= 4'd0;
      err_q        <= 7'd0;
      ferr_vec_q   <= 6'd0;
      ferr_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vec_q        <= vec_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      ferr_vec_q   <= ferr_vec_d;
      ferr_valid_q <= ferr_valid_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    vec_d        = vec_q;
    wait_d       = wait_q;
    err_d        = err_q;
    ferr_vec_d   = ferr_vec_q;
    ferr_valid_d = ferr_valid_q;
    pass_d       = pass_q;

    case (state_q)
      ST_IDLE: begin
        // start is only looked at here, so it is ignored while busy.
        if (start && !abort) begin
          idx_d        = 6'd0;
          vec_d        = 6'd0;
          wait_d       = 4'd0;
          err_d        = 7'd0;
          ferr_vec_d   = 6'd0;
          ferr_valid_d = 1'b0;
          pass_d       = 1'b0;
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        // abort wins over the comparison: nothing is counted this cycle.
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (mismatch) begin
            // At most 64 samples per sweep, so this guard never blocks a
            // legitimate increment; it just pins the ceiling explicitly.
            if (err_q < 7'd64) begin
              err_d = err_q + 7'd1;
            end
            if (!ferr_valid_q) begin
              ferr_vec_d   = vec_q;
              ferr_valid_d = 1'b1;
            end
          end
          if (idx_q == 6'd63) begin
            state_d = ST_DONE;
          end else begin
            // vec_out only moves here, on the edge back into SETTLE.
            idx_d   = idx_q + 6'd1;
            vec_d   = idx_q + 6'd1;
            wait_d  = 4'd0;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        // err_q already includes the final SAMPLE's increment.
        pass_d  = abort ? 1'b0 : (err_q == 7'd0);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign vec_out         = vec_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_vec   = ferr_vec_q;
  assign first_err_valid = ferr_valid_q;

endmodule

// File: tb/tb_lab1_sweep_checker.sv
module tb_lab1_sweep_checker;

  logic       clk;
  logic       rst_n;

  // Unit with default SETTLE=2
  logic       start, abort;
  logic [5:0] vec_out;
  logic [1:0] res_a, res_b;
  logic       busy, done, pass, first_err_valid;
  logic [6:0] err_count;
  logic [5:0] first_err_vec;
  int         mode;  // 0: equal, 1: fault at vector 37, 2: all inverted

  // Unit with SETTLE=1 for the vector walk
  logic       start1, abort1;
  logic [5:0] vec_out1;
  logic [1:0] res_a1, res_b1;
  logic       busy1, done1, pass1, first_err_valid1;
  logic [6:0] err_count1;
  logic [5:0] first_err_vec1;

  int total = 0;
  int bad   = 0;

  lab1_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_out(vec_out), .res_a(res_a), .res_b(res_b),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );

  lab1_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .vec_out(vec_out1), .res_a(res_a1), .res_b(res_b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .first_err_vec(first_err_vec1), .first_err_valid(first_err_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference circuit: any deterministic function of the vector will do.
  assign res_a  = {vec_out[5] ^ vec_out[2], vec_out[0] ^ vec_out[3] ^ vec_out[4]};
  assign res_a1 = {vec_out1[5] ^ vec_out1[2], vec_out1[0] ^ vec_out1[3] ^ vec_out1[4]};
  assign res_b1 = res_a1;

  always_comb begin
    res_b = res_a;
    if (mode == 1 && vec_out == 6'd37) res_b = res_a ^ 2'b01;
    else if (mode == 2)                res_b = ~res_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start across one rising edge; returns at the negedge after it.
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the start edge to the first cycle with done=1 (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 400);
  endtask

  task automatic wait_vec(input logic [5:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (vec_out == v && busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  int cyc;
  bit ok;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    start1 = 1'b0; abort1 = 1'b0;

    // ---- reset state ----
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec",  32'(vec_out), 32'd0);
    chk("rst_err",  32'(err_count), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_rst", 32'(busy), 32'd0);
    $display("reset: busy=%0d vec=%0d err=%0d", busy, vec_out, err_count);

    // ---- abort held with start in IDLE: stays idle ----
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_start_abort", 32'(busy), 32'd0);
    $display("idle start+abort: busy=%0d", busy);

    // ---- clean sweep ----
    mode = 0;
    kick();
    chk("clean_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("clean_done_cyc", 32'(cyc), 32'd192);
    @(negedge clk);
    chk("clean_done_pulse", 32'(done), 32'd0);
    chk("clean_idle", 32'(busy), 32'd0);
    chk("clean_err", 32'(err_count), 32'd0);
    chk("clean_pass", 32'(pass), 32'd1);
    chk("clean_fvalid", 32'(first_err_valid), 32'd0);
    $display("clean sweep: cyc=%0d err=%0d pass=%0d", cyc, err_count, pass);

    // ---- results hold in IDLE ----
    @(negedge clk);
    @(negedge clk);
    chk("hold_pass", 32'(pass), 32'd1);

    // ---- single fault at vector 37 ----
    mode = 1;
    kick();
    chk("single_cleared_pass", 32'(pass), 32'd0);
    wait_done(cyc);
    chk("single_done_cyc", 32'(cyc), 32'd192);
    @(negedge clk);
    chk("single_err", 32'(err_count), 32'd1);
    chk("single_fvec", 32'(first_err_vec), 32'd37);
    chk("single_fvalid", 32'(first_err_valid), 32'd1);
    chk("single_pass", 32'(pass), 32'd0);
    $display("single fault: err=%0d fvec=%0d pass=%0d", err_count, first_err_vec, pass);

    // ---- all fault ----
    mode = 2;
    kick();
    chk("allf_cleared_fvalid", 32'(first_err_valid), 32'd0);
    wait_done(cyc);
    chk("allf_done_cyc", 32'(cyc), 32'd192);
    @(negedge clk);
    chk("allf_err", 32'(err_count), 32'd64);
    chk("allf_fvec", 32'(first_err_vec), 32'd0);
    chk("allf_fvalid", 32'(first_err_valid), 32'd1);
    chk("allf_pass", 32'(pass), 32'd0);
    $display("all fault: cyc=%0d err=%0d fvec=%0d pass=%0d", cyc, err_count, first_err_vec, pass);

    // ---- abort during SETTLE at vector 10 (vectors 0..9 counted) ----
    mode = 2;
    kick();
    wait_vec(6'd10, ok);
    chk("abort_reach_vec10", 32'(ok), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err_hold", 32'(err_count), 32'd10);
    chk("abort_fvalid_hold", 32'(first_err_valid), 32'd1);
    chk("abort_pass", 32'(pass), 32'd0);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) cyc++;
    end
    chk("abort_no_done", 32'(cyc), 32'd0);
    $display("abort at vec 10: busy=%0d err=%0d", busy, err_count);

    // ---- abort in the SAMPLE cycle of vector 3: no increment ----
    kick();
    wait_vec(6'd3, ok);
    chk("abort2_reach_vec3", 32'(ok), 32'd1);
    @(negedge clk);
    @(negedge clk);  // now in SAMPLE for vector 3, mismatch present
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort2_busy", 32'(busy), 32'd0);
    chk("abort2_err", 32'(err_count), 32'd3);
    $display("abort in sample at vec 3: err=%0d", err_count);

    // ---- restart after abort ----
    mode = 0;
    kick();
    chk("restart_vec", 32'(vec_out), 32'd0);
    chk("restart_err", 32'(err_count), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("restart_done_cyc", 32'(cyc), 32'd192);
    @(negedge clk);
    chk("restart_pass", 32'(pass), 32'd1);
    $display("restart sweep: cyc=%0d pass=%0d", cyc, pass);

    // ---- asynchronous reset mid-sweep ----
    mode = 2;
    kick();
    for (int i = 0; i < 50; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_vec", 32'(vec_out), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    chk("arst_fvec", 32'(first_err_vec), 32'd0);
    chk("arst_fvalid", 32'(first_err_valid), 32'd0);
    chk("arst_pass", 32'(pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("arst_stay_idle", 32'(busy), 32'd0);
    $display("async reset mid-sweep: busy=%0d err=%0d", busy, err_count);

    // ---- vector walk, SETTLE=1, stray start pulses ignored ----
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 128; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("walk_vec_k%0d", k), 32'(vec_out1), 32'(k / 2));
      start1 = (k == 20 || k == 77);
    end
    start1 = 1'b0;
    @(negedge clk);
    chk("walk_done", 32'(done1), 32'd1);
    @(negedge clk);
    chk("walk_idle", 32'(busy1), 32'd0);
    chk("walk_pass", 32'(pass1), 32'd1);
    $display("vector walk: last vec=%0d pass=%0d", vec_out1, pass1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
